// File: rtl/button_pkg.sv
// button_pkg: shared types and constants for the button conditioning stage
package button_pkg;
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;
  localparam int DEBOUNCE_DEFAULT = 1000000;
  localparam int START_BTN_IDX = 4;
endpackage

// File: rtl/button_debounce_channel.sv
// button_debounce_channel: synchroniser, debounce FSM and edge pulses for one active-low button
module button_debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic sync1_q, sync2_q, pressed;
  btn_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_q, press_d, release_q, release_d;
  assign pressed = ~sync2_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    release_d = 1'b0;
    case (state_q)
      RELEASED: if (pressed) begin
        state_d = PRESS_WAIT;
        cnt_d = '0;
      end
      PRESS_WAIT: if (!pressed) begin
        state_d = RELEASED;
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        state_d = PRESSED;
        cnt_d = '0;
        level_d = 1'b1;
        press_d = 1'b1;
      end else cnt_d = cnt_q + CW'(1);
      PRESSED: if (!pressed) begin
        state_d = RELEASE_WAIT;
        cnt_d = '0;
      end
      RELEASE_WAIT: if (pressed) begin
        state_d = PRESSED;
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        state_d = RELEASED;
        cnt_d = '0;
        level_d = 1'b0;
        release_d = 1'b1;
      end else cnt_d = cnt_q + CW'(1);
      default: state_d = RELEASED;
    endcase
  end
  // Synchroniser resets to released so a held button is re-detected as a fresh press
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= RELEASED;
      cnt_q <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      release_q <= release_d;
    end
  end
  assign btn_level = level_q;
  assign press_pulse = press_q;
  assign release_pulse = release_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: N_BTN independent debounced button channels with press/release strobes
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN = 5,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk(clk),
      .reset(reset),
      .btn_n(btn_n[i]),
      .btn_level(btn_level[i]),
      .press_pulse(press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: randomized and directed stimulus against a run-length reference model
module tb_button_conditioner;
  localparam int N = 5;
  localparam int D = 4;
  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] btn_n = '1;
  logic [N-1:0] btn_level, press_pulse, release_pulse;
  exp_t exp_q[$];
  int run[N];
  logic [N-1:0] lvl_m = '0;
  int total = 0, bad = 0;
  bit armed = 0;
  always #5 clk = ~clk;
  button_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .reset(reset),
    .btn_n(btn_n),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );
  // Model: a change is accepted once D+1 consecutive samples disagree with the
  // accepted level; the result becomes visible two edges later (synchroniser).
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      e = '0;
      if (reset) begin
        exp_q.delete();
        lvl_m = '0;
        for (int i = 0; i < N; i++) run[i] = 0;
        repeat (3) exp_q.push_back(e);
        armed = 1;
      end else begin
        for (int i = 0; i < N; i++) begin
          run[i] = (btn_n[i] == lvl_m[i]) ? run[i] + 1 : 0;
          if (run[i] == D + 1) begin
            lvl_m[i] = ~lvl_m[i];
            run[i] = 0;
            e.prs[i] = lvl_m[i];
            e.rel[i] = ~lvl_m[i];
          end
        end
        e.lvl = lvl_m;
        exp_q.push_back(e);
      end
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (armed) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          if ({btn_level, press_pulse, release_pulse} !== e) begin
            bad++;
            $display("FAIL outputs t=%0t got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=%b",
                     $time, btn_level, press_pulse, release_pulse, e.lvl, e.prs, e.rel);
          end
        end
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int hold[N];
    cyc(2);
    reset = 1'b0;
    cyc(3);
    btn_n[0] = 1'b0; cyc(10);
    btn_n[0] = 1'b1; cyc(10);
    btn_n[1] = 1'b0; cyc(3);
    btn_n[1] = 1'b1; cyc(1);
    btn_n[1] = 1'b0; cyc(10);
    btn_n[1] = 1'b1; cyc(10);
    btn_n[2] = 1'b0; cyc(10);
    btn_n[2] = 1'b1; cyc(2);
    btn_n[2] = 1'b0; cyc(10);
    btn_n[2] = 1'b1; cyc(10);
    btn_n[4:3] = 2'b00; cyc(10);
    btn_n = '1; cyc(10);
    btn_n[0] = 1'b0; cyc(3);
    reset = 1'b1; cyc(1);
    reset = 1'b0; cyc(12);
    btn_n = '1; cyc(10);
    for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 12);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          btn_n[i] = ~btn_n[i];
          hold[i] = $urandom_range(1, 12);
        end
      end
      reset = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    reset = 1'b0;
    cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
